// File: rtl/fifo_memory.sv
// rtl/fifo_memory.sv - FIFO storage array: synchronous write port, combinational read port.
module fifo_memory #(
  parameter int DSIZE     = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 wclk_en,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DSIZE-1:0]     wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DSIZE-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Whole array clears asynchronously so rdata reads zero the moment reset asserts.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wclk_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: tb/tb_fifo_memory.sv
// tb/tb_fifo_memory.sv - directed self-checking bench for fifo_memory.
module tb_fifo_memory;

  logic       wclk;
  logic       wrst_n;
  logic       wclk_en;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic [3:0] raddr;
  logic [7:0] rdata;

  int checks;
  int errors;

  fifo_memory #(.DSIZE(8), .ADDR_SIZE(4)) dut (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .wclk_en (wclk_en),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (raddr),
    .rdata   (rdata)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input int a, input logic [7:0] exp);
    raddr = 4'(a);
    #1;
    check($sformatf("%s[%0d]", tag, a), rdata, exp);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    wrst_n  = 1'b1;
    wclk_en = 1'b0;
    waddr   = '0;
    wdata   = '0;
    raddr   = '0;

    // Reset then read every address
    #1 wrst_n = 1'b0;
    for (int a = 0; a < 16; a++) read_check("reset_read", a, 8'h00);
    @(negedge wclk) wrst_n = 1'b1;
    read_check("post_reset_read", 7, 8'h00);

    // Sequential fill: mem[k] = 4*k
    for (int k = 1; k <= 10; k++) begin
      @(negedge wclk);
      wclk_en = 1'b1;
      waddr   = 4'(k);
      wdata   = 8'(4 * k);
    end
    @(negedge wclk) wclk_en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge wclk);
      read_check("fill_read", k, 8'(4 * k));
    end
    read_check("fill_untouched", 0, 8'h00);
    for (int a = 11; a < 16; a++) read_check("fill_untouched", a, 8'h00);

    // Enable gating
    @(negedge wclk);
    wclk_en = 1'b0;
    waddr   = 4'd3;
    wdata   = 8'hFF;
    repeat (3) @(negedge wclk);
    read_check("enable_gating", 3, 8'h0C);

    // Same-address read/write: old data before the edge, new after
    @(negedge wclk);
    raddr   = 4'd5;
    waddr   = 4'd5;
    wdata   = 8'hA5;
    wclk_en = 1'b1;
    #1 check("same_addr_before", rdata, 8'h14);
    @(posedge wclk);
    #1 check("same_addr_after", rdata, 8'hA5);
    @(negedge wclk) wclk_en = 1'b0;

    // Full range write of ~addr, then overwrite address 15
    for (int a = 0; a < 16; a++) begin
      @(negedge wclk);
      wclk_en = 1'b1;
      waddr   = 4'(a);
      wdata   = 8'hFF ^ 8'(a);
    end
    @(negedge wclk);
    waddr = 4'd15;
    wdata = 8'h3C;
    @(negedge wclk) wclk_en = 1'b0;
    for (int a = 0; a < 15; a++) read_check("full_range", a, 8'hFF ^ 8'(a));
    read_check("overwrite_15", 15, 8'h3C);

    // Back-to-back writes to the same address: last wins
    @(negedge wclk);
    wclk_en = 1'b1;
    waddr   = 4'd9;
    wdata   = 8'h5A;
    @(negedge wclk) wdata = 8'h6B;
    @(negedge wclk) wclk_en = 1'b0;
    read_check("last_write_wins", 9, 8'h6B);

    // Async reset mid-stream
    @(negedge wclk);
    wclk_en = 1'b1;
    waddr   = 4'd2;
    wdata   = 8'h11;
    @(negedge wclk);
    waddr = 4'd4;
    wdata = 8'h22;
    read_check("stream_pre_reset", 2, 8'h11);
    #1 wrst_n = 1'b0;
    read_check("async_clear", 2, 8'h00);
    read_check("async_clear", 15, 8'h00);
    @(posedge wclk);
    #1;
    read_check("discarded_write", 4, 8'h00);
    @(negedge wclk);
    wrst_n = 1'b1;
    waddr  = 4'd6;
    wdata  = 8'h33;
    @(posedge wclk);
    #1;
    read_check("resume_write", 6, 8'h33);
    read_check("resume_other", 4, 8'h00);
    @(negedge wclk) wclk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
